// File: rtl/edge_conv_if.sv
// dstream link: a data word moves in any cycle where valid and ready are both high.
// The source drives data/valid, the sink drives ready.
interface edge_conv_if #(
    parameter int W = 30
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/edge_conv.sv
// edge_conv: streaming 3x3 Laplacian edge filter over raster-order RGB pixels.
// Each accepted pixel is reduced to 10-bit gray. Two line buffers supply the
// rows above, and a small window supplies the columns to the left. The output
// for input (row, col) is the kernel centred on (row-1, col-1). The output is
// forced to 0 on the two leading rows and columns of every frame. A single
// output register gives 1-cycle latency and full throughput.
module edge_conv #(
    parameter int W            = 30,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       reset,
    edge_conv_if.slave  x,
    edge_conv_if.master y
);

    localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    // Gray = (R + 2G + B) >> 2. The sum is at most 4092, so 12 bits is enough.
    function automatic logic [9:0] to_gray(input logic [29:0] px);
        logic [11:0] sum;
        sum = {2'b00, px[29:20]} + {1'b0, px[19:10], 1'b0} + {2'b00, px[9:0]};
        return 10'(sum >> 2);
    endfunction

    // |4c - n - s - e - w| clamped to 1023. The 13-bit signed result spans -4092..4092.
    function automatic logic [9:0] edge_mag(
        input logic [9:0] c,
        input logic [9:0] n,
        input logic [9:0] s,
        input logic [9:0] e,
        input logic [9:0] w
    );
        logic [12:0] lap;
        logic [12:0] abs_v;
        lap   = {1'b0, c, 2'b00} - {3'b000, n} - {3'b000, s}
              - {3'b000, e} - {3'b000, w};
        abs_v = lap[12] ? (13'd0 - lap) : lap;
        return (abs_v > 13'd1023) ? 10'd1023 : abs_v[9:0];
    endfunction

    // Raster position of the pixel currently offered on x.
    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;

    // lb_near_r holds row-1 and lb_far_r holds row-2, both indexed by column.
    logic [9:0] lb_near_r [IMAGE_WIDTH];
    logic [9:0] lb_far_r  [IMAGE_WIDTH];

    // Window taps from earlier columns. Column col comes straight from the
    // buffers and the input. The corner taps do not enter the kernel, so only
    // these four are stored.
    logic [9:0] top_c1_r;    // (row-2, col-1): north
    logic [9:0] mid_c1_r;    // (row-1, col-1): centre
    logic [9:0] mid_c2_r;    // (row-1, col-2): west
    logic [9:0] bot_c1_r;    // (row,   col-1): south

    logic         y_valid_r;
    logic [W-1:0] y_data_r;

    logic       accept_s;
    logic [9:0] gray_s;
    logic [9:0] top_in_s;
    logic [9:0] mid_in_s;
    logic       border_s;
    logic [9:0] mag_s;

    // Accept when the register is empty or is draining this cycle. Hold off during reset.
    assign x.ready = !reset && (y.ready || !y_valid_r);
    assign y.valid = y_valid_r;
    assign y.data  = y_data_r;

    // Per-pixel datapath: gray conversion, buffer read, kernel, border suppression.
    always_comb begin
        accept_s = x.valid && x.ready;
        gray_s   = to_gray(x.data);
        top_in_s = lb_far_r[col_r];
        mid_in_s = lb_near_r[col_r];
        border_s = (row_r < ROW_W'(2)) || (col_r < COL_W'(2));
        if (border_s) begin
            mag_s = 10'd0;
        end else begin
            mag_s = edge_mag(mid_c1_r, top_c1_r, bot_c1_r, mid_in_s, mid_c2_r);
        end
    end

    // Column/row counters advance on each accepted pixel and wrap at the frame end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_r <= '0;
            row_r <= '0;
        end else if (accept_s) begin
            if (col_r == COL_W'(IMAGE_WIDTH - 1)) begin
                col_r <= '0;
                if (row_r == ROW_W'(IMAGE_HEIGHT - 1)) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + ROW_W'(1);
                end
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Line buffers: shift this column down one row and store the new gray value.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb_far_r[col_r]  <= lb_near_r[col_r];
            lb_near_r[col_r] <= gray_s;
        end
    end

    // Window taps shift left by one column on each accepted pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_c1_r <= 10'd0;
            mid_c1_r <= 10'd0;
            mid_c2_r <= 10'd0;
            bot_c1_r <= 10'd0;
        end else if (accept_s) begin
            top_c1_r <= top_in_s;
            mid_c2_r <= mid_c1_r;
            mid_c1_r <= mid_in_s;
            bot_c1_r <= gray_s;
        end else begin
            top_c1_r <= top_c1_r;
            mid_c1_r <= mid_c1_r;
            mid_c2_r <= mid_c2_r;
            bot_c1_r <= bot_c1_r;
        end
    end

    // Output register: reload on accept, empty when drained without a new pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_valid_r <= 1'b0;
            y_data_r  <= '0;
        end else if (accept_s) begin
            y_valid_r <= 1'b1;
            y_data_r  <= W'({mag_s, mag_s, mag_s});
        end else if (y.ready) begin
            y_valid_r <= 1'b0;
            y_data_r  <= y_data_r;
        end else begin
            y_valid_r <= y_valid_r;
            y_data_r  <= y_data_r;
        end
    end

endmodule

// File: tb/tb_edge_conv.sv
// Directed bench for edge_conv on an 8x6 image: constant image, single bright
// pixel, saturation, random image with and without backpressure, and reset mid-frame.
module tb_edge_conv;

    localparam int W  = 30;
    localparam int IW = 8;
    localparam int IH = 6;
    localparam int FR = IW * IH;

    logic clk = 1'b0;
    logic reset;

    edge_conv_if #(.W(W)) x_if ();
    edge_conv_if #(.W(W)) y_if ();

    edge_conv #(.W(W), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)) dut (
        .clk   (clk),
        .reset (reset),
        .x     (x_if),
        .y     (y_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [29:0] in_mem  [0:199];
    logic [29:0] exp_mem [0:199];

    task automatic check(input string tag, input logic [29:0] obs, input logic [29:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] gray3(input int v);
        logic [9:0] m;
        m = 10'(v);
        return {m, m, m};
    endfunction

    function automatic int gray_of(input logic [29:0] px);
        return (int'(px[29:20]) + 2 * int'(px[19:10]) + int'(px[9:0])) / 4;
    endfunction

    // Reference: the kernel is computed directly on the frame held in in_mem.
    function automatic logic [29:0] model(input int k);
        int p, r, c, ci, lap;
        p = k % FR;
        r = p / IW;
        c = p % IW;
        if (r < 2 || c < 2) return 30'd0;
        ci  = (k - p) + (r - 1) * IW + (c - 1);
        lap = 4 * gray_of(in_mem[ci]) - gray_of(in_mem[ci - IW]) - gray_of(in_mem[ci + IW])
            - gray_of(in_mem[ci - 1]) - gray_of(in_mem[ci + 1]);
        if (lap < 0) lap = -lap;
        if (lap > 1023) lap = 1023;
        return gray3(lap);
    endfunction

    // Load a frame with one pixel set at (3,3) and its hand-computed outputs.
    task automatic load_bright(input logic [29:0] pix, input int cv, input int nv);
        for (int p = 0; p < FR; p++) begin
            int r, c;
            r = p / IW;
            c = p % IW;
            in_mem[p] = (p == 3 * IW + 3) ? pix : 30'd0;
            if (r == 4 && c == 4)                                          exp_mem[p] = gray3(cv);
            else if (((r == 3 || r == 5) && c == 4) || (r == 4 && (c == 3 || c == 5))) exp_mem[p] = gray3(nv);
            else                                                           exp_mem[p] = 30'd0;
        end
    endtask

    // Stream n pixels from in_mem and compare the outputs with exp_mem, optionally with random y.ready.
    task automatic run_stream(input int n, input bit bp, input string tag);
        int   in_idx, out_idx, cyc;
        logic acc_prev, vprev, rprev;
        logic [29:0] held;
        in_idx = 0; out_idx = 0; cyc = 0;
        acc_prev = 1'b0; vprev = 1'b0; rprev = 1'b0; held = 30'd0;
        while (out_idx < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            check({tag, " valid"}, 30'(y_if.valid), 30'(acc_prev || (vprev && !rprev)));
            if (vprev && !rprev) check({tag, " stable"}, y_if.data, held);
            y_if.ready = bp ? 1'($urandom_range(1, 0)) : 1'b1;
            x_if.valid = (in_idx < n);
            x_if.data  = (in_idx < n) ? in_mem[in_idx] : 30'd0;
            #1;
            if (y_if.valid && !y_if.ready) check({tag, " xready_low"}, 30'(x_if.ready), 30'd0);
            if (y_if.valid && y_if.ready) begin
                check($sformatf("%s out%0d", tag, out_idx), y_if.data, exp_mem[out_idx]);
                out_idx++;
            end
            acc_prev = x_if.valid && x_if.ready;
            if (acc_prev) in_idx++;
            vprev = y_if.valid;
            rprev = y_if.ready;
            held  = y_if.data;
        end
        if (out_idx < n) check({tag, " timeout_outputs"}, 30'(out_idx), 30'(n));
        x_if.valid = 1'b0;
        y_if.ready = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        x_if.valid = 1'b0;
        x_if.data  = 30'd0;
        y_if.ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset y.valid", 30'(y_if.valid), 30'd0);
        check("reset y.data",  y_if.data,       30'd0);
        check("reset x.ready", 30'(x_if.ready), 30'd0);
        reset = 1'b0;
        #1;
        check("idle x.ready", 30'(x_if.ready), 30'd1);

        // Constant image (G=1, gray 0) over three frames: all outputs are zero.
        for (int i = 0; i < 3 * FR; i++) begin
            in_mem[i]  = 30'd1024;
            exp_mem[i] = 30'd0;
        end
        run_stream(3 * FR, 1'b0, "const");

        // A single gray-100 pixel at (3,3).
        load_bright({10'd100, 10'd100, 10'd100}, 400, 100);
        run_stream(FR, 1'b0, "bright");

        // Saturation: a gray-1023 pixel clamps to 1023 at the centre and its neighbours.
        load_bright(30'h3FFFFFFF, 1023, 1023);
        run_stream(FR, 1'b0, "sat");

        // Random nonzero image over two frames, then the same image under backpressure.
        for (int i = 0; i < 2 * FR; i++) in_mem[i] = 30'($urandom) | 30'd1;
        for (int i = 0; i < 2 * FR; i++) exp_mem[i] = model(i);
        run_stream(2 * FR, 1'b0, "rand");
        run_stream(2 * FR, 1'b1, "rand_bp");

        // Reset after pixel (2,5) is accepted, then replay the bright-pixel frame.
        load_bright({10'd100, 10'd100, 10'd100}, 400, 100);
        run_stream(2 * IW + 6, 1'b0, "pre_rst");
        check("inflight y.valid", 30'(y_if.valid), 30'd1);
        reset = 1'b1;
        #1;
        check("midrst y.valid", 30'(y_if.valid), 30'd0);
        check("midrst y.data",  y_if.data,       30'd0);
        @(negedge clk);
        reset = 1'b0;
        run_stream(FR, 1'b0, "replay");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
